alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined ALU; successor to the combinational 64-bit datapath ALU.
//  Accepts one op per cycle over valid/ready, returns result plus N/Z/V/C flags 2 cycles later.
//  Holds an architectural NZCV flag register updated only by flag-setting ops (ADDS/SUBS style).
//  Sits between register-read and writeback in the pipelined CPU datapath.
// PARAMETERS
//  WIDTH  64  operand/result width in bits; power of 2, >= 8
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      operand bundle valid
//  in_ready   out  1      pipeline can accept this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B (shift amount for shift ops)
//  cntrl      in   3      alu_pkg::alu_op_t
//  set_flags  in   1      op updates NZCV register when it retires
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  operation result
//  negative   out  1      result[WIDTH-1]
//  zero       out  1      result == 0
//  overflow   out  1      signed overflow (ADD/SUB only, else 0)
//  carry_out  out  1      carry out (ADD/SUB only, else 0)
//  flags_q    out  4      architectural {N,Z,C,V} register
// BEHAVIOUR
//  - Ops: 000 PASS_B; 001 LSL A<<B[log2W-1:0]; 010 ADD; 011 SUB A+~B+1; 100 AND; 101 OR;
//    110 XOR; 111 LSR A>>B[log2W-1:0] (logical). Upper bits of B ignored for shifts.
//  - SUB carry_out = 1 means no borrow (A >= B unsigned). V = signed overflow of A+/-B.
//  - Reset (async, reset_n=0): s1_valid=0, s2_valid=0, out_valid=0, result=0, all flags 0,
//    flags_q=4'b0000. in_ready=1 immediately after reset.
//  - Stage S1 registers A,B,cntrl,set_flags on accept (in_valid && in_ready).
//    Stage S2 registers computed result + flags. Latency: accept at edge k -> out_valid after edge k+1.
//  - Advance rule: s2_load = s1_valid && (!s2_valid || out_ready);
//    in_ready = !s1_valid || s2_load. Full throughput 1 op/cycle while out_ready=1.
//  - Backpressure: out_ready=0 with both stages full -> in_ready=0; result/flags held stable.
//  - Simultaneous drain and fill of S1 or S2 in one cycle is legal and must not drop/duplicate ops.
//  - flags_q updates on the cycle the result retires (out_valid && out_ready) if its set_flags=1;
//    value = {negative,zero,carry_out,overflow} of that result. Non-flag ops leave flags_q unchanged.
//  - Retire of a set_flags=1 logic/shift op writes C=0, V=0.
//  - reset_n asserted mid-operation discards all in-flight ops; no partial retire.
//  - Outputs result/flags are don't-care-stable: held at last value while out_valid=0.
// CONFIGURATION
//  - ALU_SAT_EN defined: ADD/SUB saturate on signed overflow: result clamps to
//    {0,{W-1{1}}} (pos) or {1,{W-1{0}}} (neg); overflow flag still 1; N/Z from clamped result.
//  - ALU_SAT_EN undefined: ADD/SUB wrap modulo 2^WIDTH.
// STRUCTURE
//  - Package alu_pkg: alu_op_t enum (ALU_PASS_B, ALU_LSL, ALU_ADD, ALU_SUBTRACT, ALU_AND,
//    ALU_OR, ALU_XOR, ALU_LSR), flag index localparams FLAG_N/Z/C/V.
//  - One sub-module: alu_core (combinational, WIDTH-parametrised op+flags), instanced in S2.
//  - alu_pipe owns both stage registers, handshake logic and flags_q.
// TESTING
//  1. Reset: hold reset_n=0 mid-stream with 2 ops in flight -> out_valid=0, flags_q=0, in_ready=1;
//     no stale result after release.
//  2. ADD W=64: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, set_flags=1 -> result=64'h8000_0000_0000_0000,
//     N=1 V=1 C=0 Z=0 after 2 cycles; flags_q=4'b1001 after retire.
//     With ALU_SAT_EN result=64'h7FFF_FFFF_FFFF_FFFF, N=0 V=1.
//  3. SUB: A=500,B=500 -> result=0 Z=1 C=1; A=150,B=160 -> result=-10 N=1 C=0 V=0;
//     set_flags=0 -> flags_q unchanged.
//  4. Shifts: LSL A=1,B=64'h43 (amount 3) -> 8; LSR A=64'h8000_0000_0000_0000,B=63 -> 1; C=V=0.
//  5. Backpressure: stream 8 random ops, out_ready toggled 1010... and held 0 for 5 cycles ->
//     in_ready drops once 2 ops held; results retire in order, none lost or duplicated vs model.
//  6. Throughput: in_valid=out_ready=1 for 100 random ops -> 100 retires in 102 cycles, all
//     matching reference model incl. flags_q sequence.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared op encoding and NZCV flag bit positions for the pipelined ALU.
// Build option ALU_SAT_EN (see alu_core) selects saturating ADD/SUB.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_LSL      = 3'b001,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110,
    ALU_LSR      = 3'b111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit op + N/Z/V/C flag generation.
// Macro ALU_SAT_EN: ADD/SUB clamp to signed max/min on overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int SW = $clog2(WIDTH);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] arith;
  logic [SW-1:0]    shamt;

  assign sub   = (op == ALU_SUBTRACT);
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff}
               + {{WIDTH{1'b0}}, sub};
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1])
              && (sum[WIDTH-1] != a[WIDTH-1]);
  assign shamt = b[SW-1:0];

`ifdef ALU_SAT_EN
  // Both operands share a sign on overflow; that sign picks the clamp.
  assign arith = !ovf ? sum[WIDTH-1:0]
               : a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
               : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign arith = sum[WIDTH-1:0];
`endif

  // Op select; C/V only meaningful for ADD/SUB.
  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    unique case (op)
      ALU_PASS_B: result = b;
      ALU_LSL:    result = a << shamt;
      ALU_ADD, ALU_SUBTRACT: begin
        result    = arith;
        overflow  = ovf;
        carry_out = sum[WIDTH];
      end
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_LSR:    result = a >> shamt;
      default:    result = '0;
    endcase
  end

  assign negative = result[WIDTH-1];
  assign zero     = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready ALU with architectural NZCV register.
// Macro ALU_SAT_EN (in alu_core) enables saturating ADD/SUB.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  alu_op_t          cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic [3:0]       flags_q
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_t          s1_op;
  logic             s1_sf;
  logic             s2_valid;
  logic             s2_sf;

  logic             s2_load;
  logic             accept;
  logic             retire;

  logic [WIDTH-1:0] c_res;
  logic             c_n;
  logic             c_z;
  logic             c_v;
  logic             c_c;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign accept    = in_valid && in_ready;
  assign retire    = s2_valid && out_ready;
  assign out_valid = s2_valid;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a         (s1_a),
    .b         (s1_b),
    .op        (s1_op),
    .result    (c_res),
    .negative  (c_n),
    .zero      (c_z),
    .overflow  (c_v),
    .carry_out (c_c)
  );

  // S1: capture operands on accept, empty when moved on to S2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= ALU_PASS_B;
      s1_sf    <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= A;
      s1_b     <= B;
      s1_op    <= cntrl;
      s1_sf    <= set_flags;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: register computed result/flags; hold while not reloaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_sf     <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else if (s2_load) begin
      s2_valid  <= 1'b1;
      s2_sf     <= s1_sf;
      result    <= c_res;
      negative  <= c_n;
      zero      <= c_z;
      overflow  <= c_v;
      carry_out <= c_c;
    end else if (retire) begin
      s2_valid  <= 1'b0;
    end
  end

  // NZCV register: written when a flag-setting op retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
    end else if (retire && s2_sf) begin
      flags_q[FLAG_N] <= negative;
      flags_q[FLAG_Z] <= zero;
      flags_q[FLAG_C] <= carry_out;
      flags_q[FLAG_V] <= overflow;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus randomized streams vs queue model.
// Honors ALU_SAT_EN for saturating ADD/SUB expectations.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] SMAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMINV = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W+1:0] SMAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SMIN = {3'b111, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         set_flags = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  alu_op_t      cntrl = ALU_PASS_B;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         carry_out;
  logic [3:0]   flags_q;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out),
    .flags_q   (flags_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   f;
    logic         sf;
  } exp_t;

  // Reference: plain arithmetic on wide signed values.
  function automatic exp_t model(alu_op_t op, logic [W-1:0] a,
                                 logic [W-1:0] b, logic sf);
    exp_t e;
    logic signed [W+1:0] s;
    logic c;
    logic v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    e.res = '0;
    case (op)
      ALU_PASS_B: e.res = b;
      ALU_LSL:    e.res = a << (b % W);
      ALU_LSR:    e.res = a >> (b % W);
      ALU_AND:    e.res = a & b;
      ALU_OR:     e.res = a | b;
      ALU_XOR:    e.res = a ^ b;
      ALU_ADD, ALU_SUBTRACT: begin
        if (op == ALU_ADD) begin
          s = $signed({a[W-1], a[W-1], a}) + $signed({b[W-1], b[W-1], b});
          e.res = a + b;
          c = ((a + b) < a);
        end else begin
          s = $signed({a[W-1], a[W-1], a}) - $signed({b[W-1], b[W-1], b});
          e.res = a - b;
          c = (a >= b);
        end
        v = (s > SMAX) || (s < SMIN);
`ifdef ALU_SAT_EN
        if (v) e.res = (s < 0) ? SMINV : SMAXV;
`endif
      end
      default: e.res = '0;
    endcase
    e.f  = {e.res[W-1], e.res == '0, c, v};
    e.sf = sf;
    return e;
  endfunction

  exp_t         q[$];
  logic [3:0]   mflags = 4'b0000;
  bit           fresh = 1'b1;
  logic [W-1:0] n_a;
  logic [W-1:0] n_b;
  alu_op_t      n_op;
  logic         n_sf;
  int           accepted = 0;
  int           retired = 0;

  function automatic logic [W-1:0] rand_val();
    logic [W-1:0] r;
    case ($urandom_range(0, 3))
      0: r = {$urandom, $urandom};
      1: r = W'($urandom_range(0, 1000));
      2: r = SMAXV;
      default: r = SMINV;
    endcase
    return r;
  endfunction

  // One cycle of streaming: drive, check head-of-queue, update model.
  task automatic step(input bit iv, input bit ordy);
    exp_t e;
    bit   exp_rdy;
    @(negedge clk);
    if (iv && fresh) begin
      n_a  = rand_val();
      n_b  = ($urandom_range(0, 4) == 0) ? n_a : rand_val();
      n_op = alu_op_t'($urandom_range(0, 7));
      n_sf = 1'($urandom_range(0, 1));
      fresh = 1'b0;
    end
    in_valid  = iv;
    A         = n_a;
    B         = n_b;
    cntrl     = n_op;
    set_flags = n_sf;
    out_ready = ordy;
    #1;
    exp_rdy = !(q.size() >= 2 && !ordy);
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("stale_out_valid", W'(out_valid), '0);
      end else begin
        chk("result", result, q[0].res);
        chk("flags", W'({negative, zero, carry_out, overflow}), W'(q[0].f));
      end
    end
    if (out_valid && out_ready && q.size() > 0) begin
      e = q.pop_front();
      if (e.sf) mflags = e.f;
      retired++;
    end
    if (in_valid && in_ready) begin
      q.push_back(model(n_op, n_a, n_b, n_sf));
      fresh = 1'b1;
      accepted++;
    end
    @(posedge clk);
    #1;
    chk("flags_q", W'(flags_q), W'(mflags));
  endtask

  typedef struct {
    alu_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sf;
    logic [W-1:0] res;
    logic [3:0]   f;
    logic [3:0]   fq;
  } vec_t;

  localparam int NV = 12;
  vec_t tv[NV];

  initial begin
    int n;
    int a0;
    int r0;

`ifdef ALU_SAT_EN
    tv[0] = '{ALU_ADD, SMAXV, 1, 1, SMAXV, 4'b0001, 4'b0001};
`else
    tv[0] = '{ALU_ADD, SMAXV, 1, 1, SMINV, 4'b1001, 4'b1001};
`endif
    tv[1] = '{ALU_SUBTRACT, 500, 500, 1, 0, 4'b0110, 4'b0110};
    tv[2] = '{ALU_SUBTRACT, 150, 160, 1, -64'sd10, 4'b1000, 4'b1000};
    tv[3] = '{ALU_SUBTRACT, 500, 500, 0, 0, 4'b0110, 4'b1000};
    tv[4] = '{ALU_LSL, 1, 64'h43, 1, 8, 4'b0000, 4'b0000};
    tv[5] = '{ALU_LSR, SMINV, 63, 0, 1, 4'b0000, 4'b0000};
    tv[6] = '{ALU_ADD, '1, 1, 1, 0, 4'b0110, 4'b0110};
    tv[7] = '{ALU_XOR, 64'h1234, 64'h1234, 1, 0, 4'b0100, 4'b0100};
    tv[8] = '{ALU_PASS_B, 5, SMINV, 1, SMINV, 4'b1000, 4'b1000};
`ifdef ALU_SAT_EN
    tv[9] = '{ALU_SUBTRACT, SMINV, 1, 1, SMINV, 4'b1011, 4'b1011};
`else
    tv[9] = '{ALU_SUBTRACT, SMINV, 1, 1, SMAXV, 4'b0011, 4'b0011};
`endif
    tv[10] = '{ALU_AND, 64'hFF00, 64'h0FF0, 0, 64'h0F00, 4'b0000,
               tv[9].fq};
    tv[11] = '{ALU_OR, 0, 0, 1, 0, 4'b0100, 4'b0100};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_flags_q", W'(flags_q), '0);
    chk("rst_result", result, '0);
    reset_n = 1'b1;

    // Directed vectors, one op at a time, latency-checked
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      A         = tv[i].a;
      B         = tv[i].b;
      cntrl     = tv[i].op;
      set_flags = tv[i].sf;
      out_ready = 1'b1;
      #1;
      chk($sformatf("tv%0d_in_ready", i), W'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("tv%0d_lat_s1", i), W'(out_valid), '0);
      @(negedge clk);
      chk($sformatf("tv%0d_out_valid", i), W'(out_valid), 1);
      chk($sformatf("tv%0d_result", i), result, tv[i].res);
      chk($sformatf("tv%0d_flags", i),
          W'({negative, zero, carry_out, overflow}), W'(tv[i].f));
      @(negedge clk);
      chk($sformatf("tv%0d_retired", i), W'(out_valid), '0);
      chk($sformatf("tv%0d_flags_q", i), W'(flags_q), W'(tv[i].fq));
    end
    mflags = tv[NV-1].fq;

    // Backpressure: 8 ops, out_ready 1010 then held low 5 cycles
    a0 = accepted;
    r0 = retired;
    for (int i = 0; i < 4; i++) step(1'b1, (i % 2) == 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("bp_two_held", W'(q.size()), 2);
    n = 0;
    while (accepted - a0 < 8 && n < 40) begin
      step(1'b1, 1'b1);
      n++;
    end
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("bp_accepted", W'(accepted - a0), 8);
    chk("bp_retired", W'(retired - r0), 8);

    // Throughput: 100 ops back to back retire within 102 cycles
    r0 = retired;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("tp_retired", W'(retired - r0), 100);
    chk("tp_empty", W'(q.size()), '0);

    // Random valid/ready mix
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("rnd_empty", W'(q.size()), '0);

    // Make flags non-zero, then reset with two ops in flight
    @(negedge clk);
    in_valid  = 1'b1;
    A         = SMINV;
    B         = 0;
    cntrl     = ALU_PASS_B;
    set_flags = 1'b0;
    out_ready = 1'b1;
    B         = SMINV;
    set_flags = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    mflags = 4'b1000;
    chk("pre_rst_flags_q", W'(flags_q), W'(mflags));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("mid_rst_out_valid", W'(out_valid), '0);
    chk("mid_rst_flags_q", W'(flags_q), '0);
    chk("mid_rst_in_ready", W'(in_ready), 1);
    q.delete();
    mflags = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("post_rst_empty", W'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
